// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter and sequencer for an N:1 bit-select mux.
//   Grants one requester at a time, drives the mux select and registers the
//   selected data bit. A grant is held for at most MAX_BURST cycles so that
//   no requester can starve the others.
// Ports:
//   clk, rst_n  rising-edge clock, async active-low reset
//   req[N]      level-sensitive requests
//   in[N]       mux data inputs (bit i belongs to requester i)
//   gnt[N]      registered one-hot grant
//   sel         index of the granted requester
//   busy        |gnt
//   y           registered in[sel] while busy, else 0
//   y_valid     busy delayed one cycle

// Per-requester lane: flags requests at or above the scan base, so the
// cyclic scan becomes "lowest flagged, else lowest overall".
module mux_rr_lane #(
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic             req,
  input  logic [SEL_W-1:0] base,
  output logic             hi
);
  assign hi = req && (int'(base) <= IDX);
endmodule

module mux_rr_arbiter #(
  parameter int N         = 4,
  parameter int SEL_W     = $clog2(N),
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     in,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             y,
  output logic             y_valid
);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {IDLE, GRANT} state_t;

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CW-1:0]    cnt;

  logic [SEL_W-1:0] nxt;   // (sel + 1) mod N
  logic [SEL_W-1:0] base;  // scan start for this edge
  logic [N-1:0]     hi;
  logic [SEL_W-1:0] win;
  logic             hold;

  assign nxt  = (sel == SEL_W'(N - 1)) ? '0 : SEL_W'(sel + SEL_W'(1));
  // A release re-arbitrates from the successor of the current grantee in the
  // same edge, so the new pointer is used before it is registered.
  assign base = (state == GRANT) ? nxt : ptr;
  assign hold = req[sel] && (cnt < CW'(MAX_BURST));

  for (genvar i = 0; i < N; i++) begin : g_lane
    mux_rr_lane #(.SEL_W(SEL_W), .IDX(i)) u_lane (
      .req  (req[i]),
      .base (base),
      .hi   (hi[i])
    );
  end

  // Lowest index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    win = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if ((|hi) ? hi[i] : req[i]) win = SEL_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      gnt     <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      y       <= 1'b0;
      y_valid <= 1'b0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      y       <= busy ? in[sel] : 1'b0;
      y_valid <= busy;
      case (state)
        IDLE: begin
          if (|req) begin
            state <= GRANT;
            gnt   <= {{(N-1){1'b0}}, 1'b1} << win;
            sel   <= win;
            busy  <= 1'b1;
            cnt   <= CW'(1);
          end
        end
        GRANT: begin
          if (hold) begin
            cnt <= cnt + CW'(1);
          end else begin
            ptr <= nxt;
            if (|req) begin
              gnt <= {{(N-1){1'b0}}, 1'b1} << win;
              sel <= win;
              cnt <= CW'(1);
            end else begin
              state <= IDLE;
              gnt   <= '0;
              busy  <= 1'b0;
              cnt   <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;
  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] in;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       y;
  logic       y_valid;

  int checks = 0;
  int errors = 0;

  mux_rr_arbiter #(.N(4), .SEL_W(2), .MAX_BURST(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .in      (in),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .y       (y),
    .y_valid (y_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] es;
    rst_n = 1'b0;
    req   = '0;
    in    = '0;
    #3;
    chk("rst_gnt", gnt, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy_y_yv", {busy, y, y_valid}, 0);
    #9 rst_n = 1'b1;

    // 1: no requests
    for (int k = 0; k < 10; k++) begin
      step();
      chk("idle_quiet", {gnt, busy, y_valid}, 0);
    end

    // 2: each requester alone in turn, back-to-back
    in  = 4'b0110;
    req = 4'b0001; step();
    chk("t2_g0", {gnt, sel, busy}, {4'b0001, 2'd0, 1'b1});
    req = 4'b0010; step();
    chk("t2_g1", {gnt, sel, busy}, {4'b0010, 2'd1, 1'b1});
    chk("t2_y0", {y, y_valid}, {1'b0, 1'b1});
    req = 4'b0100; step();
    chk("t2_g2", {gnt, sel}, {4'b0100, 2'd2});
    chk("t2_y1", {y, y_valid}, {1'b1, 1'b1});
    req = 4'b1000; step();
    chk("t2_g3", {gnt, sel}, {4'b1000, 2'd3});
    chk("t2_y2", {y, y_valid}, {1'b1, 1'b1});
    req = 4'b0000; step();
    chk("t2_rel", {gnt, busy}, 0);
    chk("t2_y3", {y, y_valid}, {1'b0, 1'b1});
    step();
    chk("t2_yv_off", {y, y_valid}, 0);

    // 3: single requester held across several bursts, no gap
    req = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("t3_hold", {gnt, sel, busy}, {4'b0100, 2'd2, 1'b1});
    end
    req = 4'b0000; step();
    chk("t3_rel", {gnt, busy}, 0);
    // ptr now 3: requester 3 beats requester 0
    req = 4'b1001; step();
    chk("t3_ptr3", {gnt, sel}, {4'b1000, 2'd3});
    req = 4'b0000; step();
    chk("t3_rel2", busy, 0);

    // 5: early drop ends the burst (ptr wrapped to 0)
    req = 4'b0101; step();
    chk("t5_g0a", gnt, 4'b0001);
    step();
    chk("t5_g0b", gnt, 4'b0001);
    req = 4'b0100; step();
    chk("t5_g2", {gnt, sel, busy}, {4'b0100, 2'd2, 1'b1});
    req = 4'b1000; step();
    chk("t5_g3", {gnt, busy}, {4'b1000, 1'b1});
    req = 4'b0000; step();
    chk("t5_rel", busy, 0);

    // 4: all requesting -> 4-cycle bursts 0,1,2,3,0
    req = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      step();
      es = 2'((k / 4) % 4);
      chk("t4_sel", sel, es);
      chk("t4_gnt_busy", {gnt, busy}, {4'b0001 << es, 1'b1});
    end

    // 6: async reset mid-burst on requester 3
    in  = 4'b1000;
    req = 4'b1000; step();
    chk("t6_g3", {gnt, sel}, {4'b1000, 2'd3});
    step();
    chk("t6_y", {y, y_valid}, {1'b1, 1'b1});
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst", {gnt, busy, y, y_valid}, 0);
    chk("t6_rst_sel", sel, 0);
    req = 4'b1001;
    #2 rst_n = 1'b1;
    step();
    chk("t6_after", {gnt, sel, busy}, {4'b0001, 2'd0, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
